// File: rtl/uart_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader_pkg
//  Description : Shared types and constants for the UART program loader:
//                receiver state enum, default end-of-program marker and a
//                counter-width helper for the bit-timing counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [31:0] c_eop_word_default = 32'h0000_0FFF;

    // Width needed to count 0 .. clks-1.
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver. Two-flop synchroniser on the line,
//                falling-edge start detection, mid-bit sampling, LSB first.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_rx           - asynchronous serial line, idle high
//                i_en           - accept new start bits when 1
//                i_block        - refuse new start bits when 1
//                o_byte         - received byte, valid with o_byte_valid
//                o_byte_valid   - one-cycle strobe at the stop-bit sample
//                o_frame_err    - sticky framing error
//  Config      : UART_LOADER_FRAME_ERR_EN - check the stop bit, drop bad
//                bytes and flag them; otherwise every byte is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_en,
    input  logic       i_block,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int              c_cnt_w    = cnt_width(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    logic w_fall;
    logic w_half_tick;
    logic w_full_tick;
    logic w_sample;
    logic w_stop_tick;
    logic w_cnt_clr;

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_half_tick = (r_cnt == c_half_cnt);
    assign w_full_tick = (r_cnt == c_full_cnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. STOP always returns to IDLE, so a start edge
    // arriving on the byte-end cycle is only considered once back in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_fall && i_en && !i_block) w_state_next = START;
            START: if (w_half_tick) w_state_next = r_rx_sync ? IDLE : DATA;
            DATA:  if (w_full_tick && (r_bit_idx == 3'd7)) w_state_next = STOP;
            STOP:  if (w_full_tick) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_sample    = (r_state == DATA) && w_full_tick;
        w_stop_tick = (r_state == STOP) && w_full_tick;
        w_cnt_clr   = (r_state == IDLE) || (w_state_next != r_state) || w_full_tick;
    end

    // Synchroniser, bit timer and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state != DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_sample) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    assign o_byte = r_shift;

`ifdef UART_LOADER_FRAME_ERR_EN
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (w_stop_tick && !r_rx_sync) begin
            r_frame_err <= 1'b1;
        end
    end

    assign o_byte_valid = w_stop_tick & r_rx_sync;
    assign o_frame_err  = r_frame_err;
`else
    assign o_byte_valid = w_stop_tick;
    assign o_frame_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_prog_loader
//  Description : UART program loader. Receives 8N1 bytes, packs them
//                little-endian into 32-bit words and writes them to
//                consecutive instruction-memory addresses. Holds the core in
//                reset until the end-of-program word is received.
//  Ports       : wb_clk_i, wb_rst_i - clock, synchronous active-high reset
//                rx_i         - UART serial input (asynchronous, idle high)
//                en_i         - loader enable
//                mem_we_o     - one-cycle write strobe
//                mem_addr_o   - byte address of the written word
//                mem_wdata_o  - packed word
//                core_rst_o   - core reset hold, drops when load completes
//                prog_done_o  - sticky end-of-program flag
//                frame_err_o  - sticky framing error
//  Config      : UART_LOADER_FRAME_ERR_EN - enables stop-bit checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          ADDR_W       = 14,
    parameter logic [31:0] EOP_WORD     = c_eop_word_default
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    input  logic              en_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_o,
    output logic              prog_done_o,
    output logic              frame_err_o
);

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_frame_err;
    logic [31:0]       w_word;

    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word_lo;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .i_rx         (rx_i),
        .i_en         (en_i),
        .i_block      (r_done),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    // The fourth byte is combined with the three stored ones directly.
    assign w_word = {w_byte, r_word_lo};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_byte_idx <= 2'd0;
            r_word_lo  <= 24'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_done     <= 1'b0;
        end else begin
            r_we <= 1'b0;

            // Address advances the cycle after each strobe; wraps silently.
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(4);
            end

            if (w_byte_valid && !r_done) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_word_lo[7:0]   <= w_byte;
                    2'd1: r_word_lo[15:8]  <= w_byte;
                    2'd2: r_word_lo[23:16] <= w_byte;
                    default: begin
                        if (w_word == EOP_WORD) begin
                            r_done <= 1'b1;
                        end else begin
                            r_we    <= 1'b1;
                            r_wdata <= w_word;
                        end
                    end
                endcase
            end
        end
    end

    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign prog_done_o = r_done;
    assign core_rst_o  = ~r_done;
    assign frame_err_o = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_prog_loader
//  Description : Self-checking bench for uart_prog_loader. Bytes are sent
//                serially; a byte/word-level model predicts the memory writes
//                and flags, and observed writes are compared in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int          CPB = 8;
    localparam int          AW  = 8;
    localparam logic [31:0] EOP = 32'h0000_0FFF;

`ifdef UART_LOADER_FRAME_ERR_EN
    localparam bit c_ferr_en = 1'b1;
`else
    localparam bit c_ferr_en = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst;
    logic          prog_done;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (AW),
        .EOP_WORD     (EOP)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .en_i        (en),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .core_rst_o  (core_rst),
        .prog_done_o (prog_done),
        .frame_err_o (frame_err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Observed writes: {addr, data}, one entry per strobe cycle
    logic [AW+31:0] got_q[$];
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_we === 1'b1) got_q.push_back({mem_addr, mem_wdata});
    end

    // Reference model at byte/word level
    logic [AW+31:0] exp_q[$];
    int             m_idx;
    logic [31:0]    m_word;
    logic [AW-1:0]  m_addr;
    bit             m_done;
    bit             m_ferr;

    task automatic model_reset();
        m_idx = 0; m_word = 0; m_addr = 0; m_done = 0; m_ferr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (m_done) return;
        if (c_ferr_en && !stop_ok) begin
            m_ferr = 1;
            return;
        end
        m_word[8*m_idx +: 8] = b;
        m_idx++;
        if (m_idx == 4) begin
            m_idx = 0;
            if (m_word == EOP) begin
                m_done = 1;
            end else begin
                exp_q.push_back({m_addr, m_word});
                m_addr = m_addr + AW'(4);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame; optionally drop en mid-frame
    task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit drop_en);
        bit accepted;
        accepted = en;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (drop_en && i == 3) en = 1'b0;
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
        if (accepted) model_byte(b, stop_bit);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, 1'b0);
    endtask

    task automatic fill_word();
        for (int k = 0; k < 8 && m_idx != 0; k++) send_byte(8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(got_q[i][AW+31:32]), 32'(exp_q[i][AW+31:32]));
            chk({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_flags(input string tag);
        chk({tag, "_done"}, 32'(prog_done), 32'(m_done));
        chk({tag, "_core_rst"}, 32'(core_rst), 32'(!m_done));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    endtask

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        rx  = 1'b1;
        en  = 1'b1;
        model_reset();
        tick(4);
        // Reset values
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        compare_flags("rst");
        rst = 1'b0;
        tick(2);

        // Directed three-word load
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        send_word(32'h99AA_BBCC);
        compare_writes("three_words");
        compare_flags("three_words");

        // Random words
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            if (w == EOP) w = w ^ 32'h1;
            send_word(w);
        end
        compare_writes("rand_words");

        // Short low glitch while idle, then a word that must stay aligned
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(3 * CPB);
        send_word($urandom | 32'h8000_0000);
        compare_writes("glitch");

        // en dropped mid-frame: frame completes, next start ignored
        send_byte(8'($urandom), 1'b1, 1'b1);
        send_byte(8'hE7, 1'b1, 1'b0);
        en = 1'b1;
        fill_word();
        compare_writes("en_drop");

        // Bad stop bit
        send_byte(8'h5A, 1'b0, 1'b0);
        compare_flags("frame_err");
        fill_word();
        compare_writes("frame_err");
        compare_flags("frame_err_after");

        // End-of-program sequence
        do_reset();
        send_byte(8'h13, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        chk("eop_model_done", 32'(prog_done), 32'd1);
        compare_writes("eop");
        compare_flags("eop");
        // Further activity is ignored
        send_word(32'h0BAD_F00D);
        compare_writes("post_eop");
        compare_flags("post_eop");

        // Reset mid-word then a fresh word
        do_reset();
        compare_flags("after_rst");
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(2);
        chk("midword_rst_core_rst", 32'(core_rst), 32'd1);
        send_word(32'hDDCC_BBAA);
        compare_writes("midword_rst");

        // Address wrap: 65th word lands at 0
        do_reset();
        for (int i = 0; i < 65; i++) begin
            w = $urandom;
            if (w == EOP) w = w ^ 32'h1;
            send_word(w);
        end
        if (got_q.size() == 65) chk("wrap_addr", 32'(got_q[64][AW+31:32]), 32'd0);
        else chk("wrap_count", 32'(got_q.size()), 32'd65);
        compare_writes("wrap");
        compare_flags("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
